sram_master: RTL and testbench
==============================

SRAM_MASTER -- requirements
Module: sram_master

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 1, cycles address/data/cs are stable before the strobe (legal range 1..15).
REQ-002 SHALL have parameter STROBE_CYC, default 2, cycles the wr/rd strobe is asserted (legal range 1..15).
REQ-003 SHALL have parameter HOLD_CYC, default 1, cycles address/data/cs are held after the strobe (legal range 1..15).
REQ-004 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  controller accepts a request this cycle.
REQ-008 req_we  in  1  1 = write, 0 = read.
REQ-009 req_addr  in  8  target address.
REQ-010 req_wdata  in  8  write data.
REQ-011 rsp_valid  out  1  read data available.
REQ-012 rsp_ready  in  1  consumer takes read data.
REQ-013 rsp_rdata  out  8  read data.
REQ-014 sram_cs  out  1  chip select, active-high.
REQ-015 sram_wr  out  1  write strobe, active-high.
REQ-016 sram_rd  out  1  read strobe, active-low.
REQ-017 sram_addr  out  8  address to SRAM.
REQ-018 sram_din  out  8  data to SRAM.
REQ-019 sram_dout  in  8  data from SRAM, valid while sram_rd low.

Function
REQ-020 SHALL implement the states IDLE, SETUP, STROBE, HOLD and RESP, with all sram_* outputs and rsp_* outputs registered.
REQ-021 SHALL drive req_ready = 1 only in IDLE with rst low; a transfer SHALL occur on an edge with req_valid && req_ready.
REQ-022 On accept, SHALL latch req_addr into sram_addr, req_wdata into sram_din (writes only) and req_we internally, then enter SETUP.
REQ-023 Timing (accept edge = end of cycle 0, default parameters): SETUP is cycle 1, STROBE is cycles 2-3, HOLD is cycle 4, and IDLE or RESP is cycle 5.
REQ-024 SHALL hold sram_cs = 1 in SETUP, STROBE and HOLD, and sram_cs = 0 in IDLE and RESP.
REQ-025 SHALL assert sram_wr = 1 (writes) or sram_rd = 0 (reads) only in STROBE, for exactly STROBE_CYC cycles; only one of the two strobes SHALL ever be active.
REQ-026 SHALL hold sram_addr and sram_din constant from SETUP through HOLD.
REQ-027 For reads, SHALL load sram_dout into rsp_rdata at the edge ending the final STROBE cycle.
REQ-028 After HOLD, a write SHALL go to IDLE, and a read SHALL go to RESP with rsp_valid = 1.
REQ-029 In RESP, SHALL hold rsp_valid and rsp_rdata until rsp_valid && rsp_ready, then go to IDLE; rsp_valid SHALL deassert on that same edge.
REQ-030 SHALL ignore req_valid in every non-IDLE state, with no queuing.
REQ-031 A write produces no response.
REQ-032 Back-to-back latency: a write SHALL re-enable req_ready SETUP+STROBE+HOLD+1 cycles after accept (5 cycles at defaults); a read with rsp_ready tied high SHALL re-enable req_ready in cycle 6.
REQ-033 SHALL use a single 4-bit down-counter, reloaded on every state entry, for the phase lengths.

Reset
REQ-034 While rst is high at an edge, SHALL force state IDLE, sram_cs = 0, sram_wr = 0, sram_rd = 1, sram_addr = 0x00, sram_din = 0x00, rsp_valid = 0, rsp_rdata = 0x00 and counter = 0.
REQ-035 SHALL keep req_ready = 0 while rst is high.
REQ-036 Reset mid-transaction (including during a strobe) SHALL deassert the strobes at the next edge and discard any in-flight or pending response.

Structure
REQ-037 SHALL take the state enum, the 8-bit address/data width constants and the default phase-length constants from shared package sram_pkg.
REQ-038 SHALL place the phase counter in the one natural sub-module, sram_cyc_cnt (load value, enable, zero flag); the FSM remains in sram_master.

Verification
REQ-039 Write 0xA2 to 0x05 with defaults -> sram_cs = 1 in cycles 1-4, sram_wr = 1 in cycles 2-3 only, sram_addr = 0x05 and sram_din = 0xA2 stable, req_ready = 1 in cycle 5.
REQ-040 Read 0x05 after that write, SRAM model attached -> sram_rd = 0 in cycles 2-3, rsp_valid = 1 with rsp_rdata = 0xA2 in cycle 5.
REQ-041 Read 0x04 (model holds 0x3C) with rsp_ready low for 4 cycles -> rsp_valid and rsp_rdata = 0x3C held, req_ready = 0, new req_valid ignored until the handshake completes.
REQ-042 SETUP_CYC = 2, STROBE_CYC = 3, HOLD_CYC = 2, write 0x55 to 0xFF -> sram_wr high for exactly 3 cycles starting in cycle 3, req_ready returns in cycle 8.
REQ-043 rst pulsed in cycle 2 of a read -> sram_rd = 1, sram_cs = 0 and rsp_valid = 0 after the next edge; rsp_valid never asserts for the aborted read.
REQ-044 Alternating write/read to 0x00-0x0F with req_valid held high -> every read returns the last written data, strobes never overlap, and there is never more than one accept per transaction.

Source files
------------

// File: rtl/sram_pkg.sv
// ---------------------------------------------------------------------------
// sram_pkg
// Shared types and constants for the asynchronous-SRAM bus master.
//   state_e        : controller states (IDLE, SETUP, STROBE, HOLD, RESP)
//   ADDR_W/DATA_W  : SRAM address and data widths (8 bits each)
//   CNT_W          : width of the phase down-counter (phases are 1..15 cycles)
//   DEF_*_CYC      : default phase lengths in clock cycles
//   phase_load()   : converts a phase length into the counter reload value
// ---------------------------------------------------------------------------
package sram_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    localparam int DEF_SETUP_CYC  = 1;
    localparam int DEF_STROBE_CYC = 2;
    localparam int DEF_HOLD_CYC   = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

    // A phase of N cycles is timed by loading N-1 and leaving the phase on
    // the edge where the counter reads zero.
    function automatic logic [CNT_W-1:0] phase_load(input int cyc);
        return CNT_W'(cyc - 1);
    endfunction

endpackage

// File: rtl/sram_cyc_cnt.sv
// ---------------------------------------------------------------------------
// sram_cyc_cnt
// 4-bit phase down-counter used to time the SETUP/STROBE/HOLD phases.
//   clk      in  : clock, rising edge
//   rst      in  : synchronous active-high reset, clears the count
//   load     in  : reload the counter with load_val (takes priority)
//   load_val in  : reload value (phase length minus one)
//   en       in  : decrement enable; the count saturates at zero
//   zero     out : count is zero (current phase ends on this edge)
// ---------------------------------------------------------------------------
module sram_cyc_cnt
    import sram_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/sram_master.sv
// ---------------------------------------------------------------------------
// sram_master
// Single-transaction master for an asynchronous SRAM. A request accepted in
// IDLE is played out as SETUP (cs, address, data stable), STROBE (write or
// read strobe), HOLD (cs, address, data still stable). Writes then return to
// IDLE; reads present the captured data in RESP until the consumer takes it.
// All sram_* and rsp_* outputs come straight from flops.
//
// Parameters: SETUP_CYC, STROBE_CYC, HOLD_CYC -- phase lengths, 1..15 cycles.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid/req_ready      : request handshake (ready only in IDLE)
//   req_we, req_addr, req_wdata : request: 1=write, address, write data
//   rsp_valid/rsp_ready      : read-response handshake
//   rsp_rdata                : read data
//   sram_cs (act-high), sram_wr (act-high), sram_rd (act-low)
//   sram_addr, sram_din      : address and write data to the SRAM
//   sram_dout                : data from the SRAM, valid while sram_rd is low
// ---------------------------------------------------------------------------
module sram_master
    import sram_pkg::*;
#(
    parameter int SETUP_CYC  = DEF_SETUP_CYC,
    parameter int STROBE_CYC = DEF_STROBE_CYC,
    parameter int HOLD_CYC   = DEF_HOLD_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              sram_cs,
    output logic              sram_wr,
    output logic              sram_rd,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout
);

    localparam logic [CNT_W-1:0] SETUP_LD  = phase_load(SETUP_CYC);
    localparam logic [CNT_W-1:0] STROBE_LD = phase_load(STROBE_CYC);
    localparam logic [CNT_W-1:0] HOLD_LD   = phase_load(HOLD_CYC);

    state_e            state_q,     state_d;
    logic              we_q,        we_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [DATA_W-1:0] din_q,       din_d;
    logic              cs_q,        cs_d;
    logic              wr_q,        wr_d;
    logic              rd_q,        rd_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_load_val;
    logic              cnt_en;
    logic              cnt_zero;

    // Ready is combinational from the state so that it drops together with
    // rst rather than one cycle later.
    assign req_ready = (state_q == ST_IDLE) && !rst;

    sram_cyc_cnt u_cyc_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .zero     (cnt_zero)
    );

    // Next-state and registered-output logic. The counter is reloaded on
    // every state change; IDLE and RESP are untimed and reload zero.
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        addr_d       = addr_q;
        din_d        = din_q;
        cs_d         = cs_q;
        wr_d         = wr_q;
        rd_d         = rd_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_rdata_d  = rsp_rdata_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    we_d   = req_we;
                    addr_d = req_addr;
                    // Reads leave the data bus at its last written value.
                    if (req_we) begin
                        din_d = req_wdata;
                    end
                    cs_d         = 1'b1;
                    state_d      = ST_SETUP;
                    cnt_load     = 1'b1;
                    cnt_load_val = SETUP_LD;
                end
            end

            ST_SETUP: begin
                cnt_en = 1'b1;
                if (cnt_zero) begin
                    if (we_q) begin
                        wr_d = 1'b1;
                    end else begin
                        rd_d = 1'b0;
                    end
                    state_d      = ST_STROBE;
                    cnt_load     = 1'b1;
                    cnt_load_val = STROBE_LD;
                end
            end

            ST_STROBE: begin
                cnt_en = 1'b1;
                if (cnt_zero) begin
                    // Capture while sram_rd is still low on this final edge.
                    if (!we_q) begin
                        rsp_rdata_d = sram_dout;
                    end
                    wr_d         = 1'b0;
                    rd_d         = 1'b1;
                    state_d      = ST_HOLD;
                    cnt_load     = 1'b1;
                    cnt_load_val = HOLD_LD;
                end
            end

            ST_HOLD: begin
                cnt_en = 1'b1;
                if (cnt_zero) begin
                    cs_d     = 1'b0;
                    cnt_load = 1'b1;
                    if (we_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                    end
                end
            end

            ST_RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                    cnt_load    = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            cs_q        <= 1'b0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            cs_q        <= cs_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign sram_cs   = cs_q;
    assign sram_wr   = wr_q;
    assign sram_rd   = rd_q;
    assign sram_addr = addr_q;
    assign sram_din  = din_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_sram_master.sv
// ---------------------------------------------------------------------------
// tb_sram_master
// Two masters: "a" with default phase lengths and "b" with 2/3/2. Each has its
// own behavioural SRAM. Requests are steered to one master by sel. Expected
// waveforms are computed per cycle from the phase lengths, and read data comes
// from a reference memory maintained by the bench.
// ---------------------------------------------------------------------------
module tb_sram_master;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;
    logic mem_init = 1'b1;

    logic       req_valid = 1'b0;
    logic       req_we    = 1'b0;
    logic [7:0] req_addr  = 8'h00;
    logic [7:0] req_wdata = 8'h00;
    logic       rsp_ready = 1'b0;

    logic       a_req_valid, b_req_valid;
    logic       a_req_ready, b_req_ready;
    logic       a_rsp_valid, b_rsp_valid;
    logic [7:0] a_rsp_rdata, b_rsp_rdata;
    logic       a_cs, b_cs, a_wr, b_wr, a_rd, b_rd;
    logic [7:0] a_addr, b_addr, a_din, b_din, a_dout, b_dout;

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];

    logic       m_ready, m_cs, m_wr, m_rd, m_rv;
    logic [7:0] m_addr, m_din, m_rdata;

    int checks = 0;
    int errors = 0;
    int acc_a = 0;
    int acc_b = 0;
    int exp_acc [2];
    logic [7:0] ref_mem [2][256];
    logic [7:0] last_din [2];

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         rsp_wait;
        logic [7:0] exp_rdata;
    } vec_t;
    vec_t tbl [7];

    always #5 clk = ~clk;

    assign a_req_valid = req_valid & ~sel;
    assign b_req_valid = req_valid & sel;

    sram_master u_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(a_rsp_rdata),
        .sram_cs(a_cs), .sram_wr(a_wr), .sram_rd(a_rd),
        .sram_addr(a_addr), .sram_din(a_din), .sram_dout(a_dout)
    );

    sram_master #(.SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(2)) u_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(b_rsp_rdata),
        .sram_cs(b_cs), .sram_wr(b_wr), .sram_rd(b_rd),
        .sram_addr(b_addr), .sram_din(b_din), .sram_dout(b_dout)
    );

    function automatic logic [7:0] init_val(input int i);
        return (i == 4) ? 8'h3C : 8'(i * 7 + 3);
    endfunction

    // SRAM models: data only valid while the read strobe is low.
    assign a_dout = a_rd ? 8'hEE : mem_a[a_addr];
    assign b_dout = b_rd ? 8'hEE : mem_b[b_addr];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) begin
                mem_a[i] <= init_val(i);
                mem_b[i] <= init_val(i);
            end
        end else begin
            if (a_cs && a_wr) mem_a[a_addr] <= a_din;
            if (b_cs && b_wr) mem_b[b_addr] <= b_din;
        end
    end

    always @(posedge clk) begin
        if (a_req_valid && a_req_ready) acc_a <= acc_a + 1;
        if (b_req_valid && b_req_ready) acc_b <= acc_b + 1;
    end

    assign m_ready = sel ? b_req_ready : a_req_ready;
    assign m_cs    = sel ? b_cs        : a_cs;
    assign m_wr    = sel ? b_wr        : a_wr;
    assign m_rd    = sel ? b_rd        : a_rd;
    assign m_rv    = sel ? b_rsp_valid : a_rsp_valid;
    assign m_addr  = sel ? b_addr      : a_addr;
    assign m_din   = sel ? b_din       : a_din;
    assign m_rdata = sel ? b_rsp_rdata : a_rsp_rdata;

    task automatic chk(input string name, input int k, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut=%0d cycle=%0d got=%h exp=%h", name, sel, k, got, exp);
        end
    endtask

    // One transaction on the selected master, starting at a negedge. The
    // request stays valid (with junk fields) while busy to show it is ignored.
    task automatic run_txn(input logic we, input logic [7:0] addr, input logic [7:0] wd,
                           input int rsp_wait, input logic [7:0] exp_rd);
        int s, t, h, l, idx, w, j;
        logic busy, stb, done;
        logic [7:0] exp_din;
        logic [4:0] e_ctrl;
        s   = sel ? 2 : 1;
        t   = sel ? 3 : 2;
        h   = sel ? 2 : 1;
        l   = s + t + h;
        idx = sel ? 1 : 0;
        exp_din = we ? wd : last_din[idx];
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        rsp_ready = 1'b0;
        w = 0;
        while (m_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) begin
            chk("accept_timeout", 0, 32'(0), 32'(1));
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_acc[idx]++;
        if (we) begin
            last_din[idx] = wd;
            ref_mem[idx][addr] = wd;
        end
        done = 1'b0;
        for (int k = 1; k <= l + rsp_wait + 3 && !done; k++) begin
            @(negedge clk);
            busy = (k <= l);
            stb  = (k >= s + 1) && (k <= s + t);
            if (busy) begin
                e_ctrl = {1'b0, 1'b1, we & stb, ~(~we & stb), 1'b0};
            end else if (we) begin
                e_ctrl = 5'b10010;
                done = 1'b1;
            end else begin
                j = k - l;
                if (j <= rsp_wait + 1) begin
                    e_ctrl = 5'b00011;
                end else begin
                    e_ctrl = 5'b10010;
                    done = 1'b1;
                end
            end
            chk("rdy_cs_wr_rd_rv", k, 32'({m_ready, m_cs, m_wr, m_rd, m_rv}), 32'(e_ctrl));
            if (busy) chk("addr_din", k, 32'({m_addr, m_din}), 32'({addr, exp_din}));
            if (!we && !busy && !done) chk("rsp_rdata", k, 32'(m_rdata), 32'(exp_rd));
            if (k == 1) begin
                req_we    = ~we;
                req_addr  = ~addr;
                req_wdata = ~wd;
            end
            if (!we && !busy && !done) rsp_ready = ((k - l) > rsp_wait);
        end
        if (!done) chk("txn_end", 0, 32'(0), 32'(1));
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        chk("accept_count", 0, 32'(idx ? acc_b : acc_a), 32'(exp_acc[idx]));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic       seen;
        logic [7:0] a, d;
        exp_acc[0] = 0;
        exp_acc[1] = 0;
        last_din[0] = 8'h00;
        last_din[1] = 8'h00;
        for (int i = 0; i < 256; i++) begin
            ref_mem[0][i] = init_val(i);
            ref_mem[1][i] = init_val(i);
        end
        tbl[0] = '{1'b1, 8'h05, 8'hA2, 0, 8'h00};
        tbl[1] = '{1'b0, 8'h05, 8'h00, 0, 8'hA2};
        tbl[2] = '{1'b0, 8'h04, 8'h00, 4, 8'h3C};
        tbl[3] = '{1'b1, 8'h04, 8'hC3, 0, 8'h00};
        tbl[4] = '{1'b0, 8'h04, 8'h00, 1, 8'hC3};
        tbl[5] = '{1'b1, 8'h00, 8'h11, 0, 8'h00};
        tbl[6] = '{1'b0, 8'h00, 8'h00, 2, 8'h11};

        // Reset state.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_a", 0, 32'({a_req_ready, a_cs, a_wr, a_rd, a_rsp_valid, a_addr, a_din, a_rsp_rdata}),
            32'({5'b00010, 8'h00, 8'h00, 8'h00}));
        chk("reset_b", 0, 32'({b_req_ready, b_cs, b_wr, b_rd, b_rsp_valid, b_addr, b_din, b_rsp_rdata}),
            32'({5'b00010, 8'h00, 8'h00, 8'h00}));
        mem_init = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 0, 32'(a_req_ready), 32'(1));

        // Directed vectors on the default-timing master.
        sel = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (tbl[i].we) ref_mem[0][tbl[i].addr] = tbl[i].wdata;
            run_txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].rsp_wait, tbl[i].exp_rdata);
            $display("vec %0d we=%0d addr=%h wdata=%h exp_rdata=%h", i, tbl[i].we,
                     tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata);
        end

        // Random alternating write/read in 0x00-0x0F, checked against ref_mem.
        for (int i = 0; i < 16; i++) begin
            a = 8'($urandom_range(0, 15));
            d = 8'($urandom);
            run_txn(1'b1, a, d, 0, 8'h00);
            $display("rand write addr=%h data=%h", a, d);
            a = 8'($urandom_range(0, 15));
            run_txn(1'b0, a, 8'($urandom), $urandom_range(0, 2), ref_mem[0][a]);
            $display("rand read  addr=%h exp=%h", a, ref_mem[0][a]);
        end

        // Stretched timing master.
        sel = 1'b1;
        run_txn(1'b1, 8'hFF, 8'h55, 0, 8'h00);
        $display("dut_b write addr=ff data=55");
        run_txn(1'b0, 8'hFF, 8'h00, 0, 8'h55);
        $display("dut_b read  addr=ff exp=55");

        // Reset in the first strobe cycle of a read.
        sel = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 8'h05;
        @(posedge clk);
        exp_acc[0]++;
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_setup_cs", 1, 32'(a_cs), 32'(1));
        @(negedge clk);
        chk("abort_strobe_rd", 2, 32'(a_rd), 32'(0));
        rst = 1'b1;
        @(negedge clk);
        chk("abort_state", 3, 32'({a_req_ready, a_cs, a_wr, a_rd, a_rsp_valid, a_addr, a_din, a_rsp_rdata}),
            32'({5'b00010, 8'h00, 8'h00, 8'h00}));
        rst = 1'b0;
        last_din[0] = 8'h00;
        last_din[1] = 8'h00;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (a_rsp_valid) seen = 1'b1;
        end
        chk("aborted_no_rsp", 0, 32'(seen), 32'(0));
        chk("abort_ready", 0, 32'(a_req_ready), 32'(1));
        chk("abort_accepts", 0, 32'(acc_a), 32'(exp_acc[0]));
        $display("reset abort of read addr=05");

        // Recovery after the abort.
        run_txn(1'b1, 8'h09, 8'h77, 0, 8'h00);
        run_txn(1'b0, 8'h09, 8'h00, 1, 8'h77);
        $display("post-reset write/read addr=09 data=77");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
